pwm_multicanal: RTL

PWM_MULTICANAL -- requirements
Module: pwm_multicanal

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_multicanal_if.sv | 17 +
 rtl/pwm_prescaler.sv | 26 ++
 rtl/pwm_multicanal.sv | 100 ++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and width helper for the multichannel PWM block.
package pwm_pkg;

  localparam int R_DEF = 8;
  localparam int N_DEF = 4;
  localparam int F_DEF = 0;

  // The result is the number of bits needed to encode v itself.
  // This lets an out-of-range channel index such as N reach the port.
  function automatic int clog2(input int v);
    int b;
    b = 1;
    for (int i = 1; i < 32; i++) begin
      if ((v >> i) != 0) b = i + 1;
    end
    return b;
  endfunction

endpackage

// File: rtl/pwm_multicanal_if.sv
// Duty-write channel: valid/ready handshake carrying a channel index and a duty value.
interface pwm_multicanal_if
  import pwm_pkg::*;
#(
  parameter int R = R_DEF,
  parameter int N = N_DEF
);
  localparam int CW = clog2(N);

  logic          wr_valid;
  logic [CW-1:0] wr_ch;
  logic [R-1:0]  wr_duty;
  logic          wr_ready;

  modport master (output wr_valid, output wr_ch, output wr_duty, input wr_ready);
  modport slave  (input wr_valid, input wr_ch, input wr_duty, output wr_ready);
endinterface

// File: rtl/pwm_prescaler.sv
// Divides clk into a one-cycle count tick every 2^(F+1) clocks while run is high.
// The tick is combinational from the registered phase counter. The phase is held at 0 when halted.
module pwm_prescaler #(
  parameter int F = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic enable
);

  logic [F:0] pc_q, pc_d;

  always_comb begin
    pc_d = '0;
    if (run) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign enable = run & (&pc_q);

endmodule

// File: rtl/pwm_multicanal.sv
// N-channel PWM with a shared counter and shadowed duty registers that update on the period boundary.
// pwm_out is registered with one clock of latency. wr_ready drops while a channel's shadow is still pending.
module pwm_multicanal
  import pwm_pkg::*;
#(
  parameter int R        = R_DEF,
  parameter int N        = N_DEF,
  parameter int F        = F_DEF,
  parameter int DUTY_RST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  pwm_multicanal_if.slave  wr,
  output logic [N-1:0]     pwm_out,
  output logic             enable,
  output logic             period_end
);

  localparam int          CW      = clog2(N);
  localparam logic [R-1:0] CNT_MAX = '1;
  localparam logic [R-1:0] DUTY0   = R'(DUTY_RST);

  logic [R-1:0]        cnt_q, cnt_d;
  logic [N-1:0][R-1:0] act_q, act_d;
  logic [N-1:0][R-1:0] shd_q, shd_d;
  logic [N-1:0]        pend_q, pend_d;
  logic [N-1:0]        pwm_q, pwm_d;
  logic [N-1:0]        ch_sel;
  logic                ch_pend;
  logic                wr_acc;

  pwm_prescaler #(.F(F)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .enable (enable)
  );

  assign period_end = enable & (cnt_q == CNT_MAX);

  // Decode the channel index. An index at or above N selects nothing and is never ready.
  always_comb begin
    ch_sel  = '0;
    ch_pend = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (wr.wr_ch == CW'(i)) begin
        ch_sel[i] = 1'b1;
        ch_pend   = pend_q[i];
      end
    end
    wr.wr_ready = (|ch_sel) & (~run | ~ch_pend);
  end

  assign wr_acc = wr.wr_valid & wr.wr_ready;

  always_comb begin
    cnt_d = '0;
    if (run) cnt_d = enable ? cnt_q + 1'b1 : cnt_q;
  end

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    pwm_d  = '0;
    for (int i = 0; i < N; i++) begin
      // Pending shadows commit at the boundary, or immediately once the counter halts.
      if ((period_end | ~run) & pend_q[i]) begin
        act_d[i]  = shd_q[i];
        pend_d[i] = 1'b0;
      end
      if (wr_acc & ch_sel[i]) begin
        shd_d[i] = wr.wr_duty;
        if (run) pend_d[i] = 1'b1;
        else     act_d[i]  = wr.wr_duty;
      end
      pwm_d[i] = run & (cnt_q < act_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      act_q  <= {N{DUTY0}};
      shd_q  <= {N{DUTY0}};
      pend_q <= '0;
      pwm_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule
